// File: rtl/efx_ram_sdp_gen.sv
// ---------------------------------------------------------------------------
// efx_ram_sdp_gen
// Parametrised single-clock simple dual-port RAM: one write port with
// byte-lane enables and one read port. Each read is tagged with a valid flag
// and a collision flag. A read collides when it hits the address being
// written in the same cycle. Written lanes of a colliding read resolve
// according to WRITE_MODE. OUTPUT_REG adds a second read stage, which makes
// the read latency 2 instead of 1.
//
// Optional feature macro: EFX_RAM_COLLISION_CNT_EN
//   When defined, adds COLL_CNT[15:0]. This is a saturating count of the
//   COLLISION pulses presented on the output.
// ---------------------------------------------------------------------------
module efx_ram_sdp_gen #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    BYTE_WIDTH = 8,
  parameter string                 WRITE_MODE = "READ_FIRST",
  parameter int                    OUTPUT_REG = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             WCLKE,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] WE,
  input  logic [ADDR_WIDTH-1:0]            WADDR,
  input  logic [DATA_WIDTH-1:0]            WDATA,
  input  logic                             RE,
  input  logic [ADDR_WIDTH-1:0]            RADDR,
  output logic [DATA_WIDTH-1:0]            RDATA,
  output logic                             RVALID,
  output logic                             COLLISION
`ifdef EFX_RAM_COLLISION_CNT_EN
  ,
  output logic [15:0]                      COLL_CNT
`endif
);

  localparam int NBE   = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Collision resolution for the lanes that are written in the same cycle.
  typedef enum logic [1:0] {
    MODE_READ_FIRST   = 2'd0,
    MODE_WRITE_FIRST  = 2'd1,
    MODE_READ_UNKNOWN = 2'd2
  } coll_mode_e;

  localparam coll_mode_e MODE =
    (WRITE_MODE == "WRITE_FIRST")  ? MODE_WRITE_FIRST  :
    (WRITE_MODE == "READ_UNKNOWN") ? MODE_READ_UNKNOWN : MODE_READ_FIRST;

  // Elaboration-time parameter sanity checks.
  if (ADDR_WIDTH < 1) begin : g_bad_addr
    $fatal(1, "ERROR: ADDR_WIDTH must be at least 1");
  end
  if (BYTE_WIDTH < 1 || (DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
    $fatal(1, "ERROR: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (WRITE_MODE != "READ_FIRST" && WRITE_MODE != "WRITE_FIRST" &&
      WRITE_MODE != "READ_UNKNOWN") begin : g_bad_mode
    $fatal(1, "ERROR: WRITE_MODE must be READ_FIRST, WRITE_FIRST or READ_UNKNOWN");
  end

  // NOTE: the storage array has no reset. It takes INIT_VALUE once, at time 0,
  // through its declaration. Resetting it would prevent block-RAM inference.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: INIT_VALUE};

  logic                  wr_any;
  logic                  rd_collide;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  s1_valid;
  logic                  s1_coll;
  logic [DATA_WIDTH-1:0] s1_data;

  // The next value of COLLISION. It feeds the optional counter.
  logic                  coll_next;

  assign wr_any     = WCLKE && (|WE);
  assign rd_collide = RE && wr_any && (RADDR == WADDR);

  // Byte-lane write. RST suppresses the write, but it does not clear contents.
  always_ff @(posedge CLK) begin
    if (!RST && WCLKE) begin
      for (int k = 0; k < NBE; k++) begin
        if (WE[k]) begin
          mem[WADDR][k*BYTE_WIDTH +: BYTE_WIDTH] <= WDATA[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Form the read word from the old contents, then resolve colliding lanes one by one.
  always_comb begin
    // NOTE: assign the full word before the lane loop so every path drives
    // rd_word. Without this default, synthesis would infer a latch.
    rd_word = mem[RADDR];
    for (int k = 0; k < NBE; k++) begin
      if (rd_collide && WE[k]) begin
        case (MODE)
          MODE_WRITE_FIRST:  rd_word[k*BYTE_WIDTH +: BYTE_WIDTH] = WDATA[k*BYTE_WIDTH +: BYTE_WIDTH];
          MODE_READ_UNKNOWN: rd_word[k*BYTE_WIDTH +: BYTE_WIDTH] = 'x;
          default:           rd_word[k*BYTE_WIDTH +: BYTE_WIDTH] = mem[RADDR][k*BYTE_WIDTH +: BYTE_WIDTH];
        endcase
      end
    end
  end

  // Read stage 1: capture the word, its valid flag and its collision flag.
  // Data holds its value while no read is made.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments only. All registers
    // then update together at the clock edge, whatever order the blocks run in.
    if (RST) begin
      s1_valid <= 1'b0;
      s1_coll  <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= RE;
      s1_coll  <= rd_collide;
      if (RE) begin
        s1_data <= rd_word;
      end
    end
  end

  if (OUTPUT_REG != 0) begin : g_out_reg
    logic                  s2_valid;
    logic                  s2_coll;
    logic [DATA_WIDTH-1:0] s2_data;

    // Read stage 2: register stage 1 once more. Data holds its value between reads.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        s2_valid <= 1'b0;
        s2_coll  <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        s2_coll  <= s1_coll;
        if (s1_valid) begin
          s2_data <= s1_data;
        end
      end
    end

    assign RDATA     = s2_data;
    assign RVALID    = s2_valid;
    assign COLLISION = s2_coll;
    assign coll_next = s1_coll;
  end else begin : g_no_out_reg
    assign RDATA     = s1_data;
    assign RVALID    = s1_valid;
    assign COLLISION = s1_coll;
    assign coll_next = rd_collide;
  end

`ifdef EFX_RAM_COLLISION_CNT_EN
  logic [15:0] coll_cnt_q;

  // Saturating collision counter. It steps on the edge that raises COLLISION.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      coll_cnt_q <= '0;
    end else if (coll_next && coll_cnt_q != 16'hFFFF) begin
      coll_cnt_q <= coll_cnt_q + 16'd1;
    end
  end

  assign COLL_CNT = coll_cnt_q;
`else
  logic unused_coll_next;
  assign unused_coll_next = coll_next;
`endif

endmodule

// File: tb/tb_efx_ram_sdp_gen.sv
// ---------------------------------------------------------------------------
// tb_efx_ram_sdp_gen
// Three RAM instances share one stimulus stream:
//   0: READ_FIRST,   read latency 1
//   1: WRITE_FIRST,  read latency 2 (OUTPUT_REG=1)
//   2: READ_UNKNOWN, read latency 1
// Every instance is loaded with 16'h5A5A at time 0.
// A reference memory predicts each read, and the prediction is queued with
// the cycle it is due. A negedge monitor matches the DUT outputs against
// these queues.
// ---------------------------------------------------------------------------
module tb_efx_ram_sdp_gen;

  typedef struct {
    logic [15:0] data;
    logic [15:0] xmask;   // lanes whose value is undefined
    logic        coll;
    int          due;     // cycle in which RVALID must show this result
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        WCLKE = 1'b0;
  logic [1:0]  WE = '0;
  logic [7:0]  WADDR = '0;
  logic [15:0] WDATA = '0;
  logic        RE = 1'b0;
  logic [7:0]  RADDR = '0;

  logic [15:0] rdata [3];
  logic        rvalid [3];
  logic        coll [3];
`ifdef EFX_RAM_COLLISION_CNT_EN
  logic [15:0] coll_cnt [3];
`endif

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat [3] = '{1, 2, 1};
  exp_t        sb [3][$];
  logic [15:0] last_exp [3];
  logic [15:0] last_mask [3];
  int          model_cnt [3];
  logic [15:0] ref_mem [256];
  exp_t        e;

  efx_ram_sdp_gen #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .BYTE_WIDTH(8),
    .WRITE_MODE("READ_FIRST"), .OUTPUT_REG(0), .INIT_VALUE(16'h5A5A)) u_rf (
    .CLK(CLK), .RST(RST), .WCLKE(WCLKE), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .RE(RE), .RADDR(RADDR), .RDATA(rdata[0]), .RVALID(rvalid[0]), .COLLISION(coll[0])
`ifdef EFX_RAM_COLLISION_CNT_EN
    , .COLL_CNT(coll_cnt[0])
`endif
  );

  efx_ram_sdp_gen #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .BYTE_WIDTH(8),
    .WRITE_MODE("WRITE_FIRST"), .OUTPUT_REG(1), .INIT_VALUE(16'h5A5A)) u_wf (
    .CLK(CLK), .RST(RST), .WCLKE(WCLKE), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .RE(RE), .RADDR(RADDR), .RDATA(rdata[1]), .RVALID(rvalid[1]), .COLLISION(coll[1])
`ifdef EFX_RAM_COLLISION_CNT_EN
    , .COLL_CNT(coll_cnt[1])
`endif
  );

  efx_ram_sdp_gen #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .BYTE_WIDTH(8),
    .WRITE_MODE("READ_UNKNOWN"), .OUTPUT_REG(0), .INIT_VALUE(16'h5A5A)) u_ru (
    .CLK(CLK), .RST(RST), .WCLKE(WCLKE), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .RE(RE), .RADDR(RADDR), .RDATA(rdata[2]), .RVALID(rvalid[2]), .COLLISION(coll[2])
`ifdef EFX_RAM_COLLISION_CNT_EN
    , .COLL_CNT(coll_cnt[2])
`endif
  );

  initial forever #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input int m, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s at cycle %0d: got %h expected %h", m, name, cyc, act, exp);
    end
  endtask

  // Apply one cycle of stimulus, predict any read it makes, update the model.
  task automatic drive(input logic wc, input logic [1:0] we, input logic [7:0] wa,
                       input logic [15:0] wd, input logic re, input logic [7:0] ra);
    exp_t        x;
    logic        hit;
    WCLKE = wc; WE = we; WADDR = wa; WDATA = wd; RE = re; RADDR = ra;
    if (re) begin
      hit = wc && (we != 2'b00) && (ra == wa);
      for (int m = 0; m < 3; m++) begin
        x.data  = ref_mem[ra];
        x.xmask = '0;
        x.coll  = hit;
        x.due   = cyc + lat[m];
        for (int k = 0; k < 2; k++) begin
          if (hit && we[k]) begin
            if (m == 1) x.data[k*8 +: 8] = wd[k*8 +: 8];
            else if (m == 2) x.xmask[k*8 +: 8] = 8'hFF;
          end
        end
        sb[m].push_back(x);
      end
    end
    if (wc) begin
      for (int k = 0; k < 2; k++) if (we[k]) ref_mem[wa][k*8 +: 8] = wd[k*8 +: 8];
    end
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 8'h00, 16'h0000, 1'b0, 8'h00);
  endtask

  task automatic flush_model();
    for (int m = 0; m < 3; m++) begin
      sb[m].delete();
      last_exp[m]  = '0;
      last_mask[m] = '0;
      model_cnt[m] = 0;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    WCLKE = 1'b0; WE = '0; RE = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    flush_model();
    for (int m = 0; m < 3; m++) begin
      check(m, "reset_rdata", rdata[m], 16'h0000);
      check(m, "reset_rvalid", rvalid[m], 1'b0);
      check(m, "reset_collision", coll[m], 1'b0);
    end
    RST = 1'b0;
  endtask

  // Monitor: match each presented result against the scoreboard.
  always @(negedge CLK) begin
    if (!RST) begin
      for (int m = 0; m < 3; m++) begin
        if (rvalid[m]) begin
          if (sb[m].size() == 0) begin
            check(m, "unexpected_rvalid", rvalid[m], 1'b0);
          end else begin
            e = sb[m].pop_front();
            check(m, "latency", cyc, e.due);
            check(m, "rdata", rdata[m] & ~e.xmask, e.data & ~e.xmask);
            check(m, "collision", coll[m], e.coll);
            last_exp[m]  = e.data;
            last_mask[m] = e.xmask;
            if (e.coll) model_cnt[m]++;
          end
        end else begin
          check(m, "collision_idle", coll[m], 1'b0);
          check(m, "rdata_hold", rdata[m] & ~last_mask[m], last_exp[m] & ~last_mask[m]);
          if (sb[m].size() != 0 && sb[m][0].due <= cyc) begin
            check(m, "missing_rvalid", rvalid[m], 1'b1);
            void'(sb[m].pop_front());
          end
        end
`ifdef EFX_RAM_COLLISION_CNT_EN
        check(m, "coll_cnt", coll_cnt[m], (model_cnt[m] > 65535) ? 16'hFFFF : model_cnt[m][15:0]);
`endif
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h5A5A;
    flush_model();
    do_reset();

    // Stream 257 reads over an untouched array; the address wraps back to 0.
    for (int i = 0; i < 257; i++) drive(1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'(i));
    idle(3);

    // Basic write and read, then a low-lane-only update.
    drive(1'b1, 2'b11, 8'h10, 16'hA5C3, 1'b0, 8'h00);
    drive(1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h10);
    idle(2);
    drive(1'b1, 2'b01, 8'h10, 16'h1234, 1'b0, 8'h00);
    drive(1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h10);
    idle(2);

    // Collision on the high lane of 16'h00FF.
    drive(1'b1, 2'b11, 8'h20, 16'h00FF, 1'b0, 8'h00);
    drive(1'b1, 2'b10, 8'h20, 16'hABCD, 1'b1, 8'h20);
    drive(1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h20);
    // Write with WCLKE=0 or WE=0 at the read address: no change, no collision.
    drive(1'b0, 2'b11, 8'h20, 16'h1111, 1'b1, 8'h20);
    drive(1'b1, 2'b00, 8'h20, 16'h2222, 1'b1, 8'h20);
    idle(3);

    // Randomised traffic over a small address window to provoke collisions.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 7)),
            16'($urandom), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)));
    end

    // Reset while reads are in flight; the attempted write during reset must not land.
    drive(1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h01);
    drive(1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h02);
    RST = 1'b1;
    WCLKE = 1'b1; WE = 2'b11; WADDR = 8'h30; WDATA = 16'hFFFF; RE = 1'b1; RADDR = 8'h30;
    #1;
    flush_model();
    for (int m = 0; m < 3; m++) begin
      check(m, "midreset_rdata", rdata[m], 16'h0000);
      check(m, "midreset_rvalid", rvalid[m], 1'b0);
    end
    repeat (3) @(posedge CLK);
    #1;
    WCLKE = 1'b0; WE = '0; RE = 1'b0;
    RST = 1'b0;
    idle(4);
    drive(1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h30);
    idle(3);

`ifdef EFX_RAM_COLLISION_CNT_EN
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 2'b11, 8'h40, 16'($urandom), 1'b1, 8'h40);
    for (int i = 0; i < 2; i++) drive(1'b1, 2'b11, 8'h41, 16'($urandom), 1'b1, 8'h42);
    idle(3);
    for (int m = 0; m < 3; m++) check(m, "coll_cnt_three", coll_cnt[m], 16'd3);
    for (int i = 0; i < 65531; i++) drive(1'b1, 2'b01, 8'h40, 16'($urandom), 1'b1, 8'h40);
    for (int m = 0; m < 3; m++) check(m, "coll_cnt_fffe", coll_cnt[m], 16'hFFFE - 16'(lat[m] - 1));
    for (int i = 0; i < 2; i++) drive(1'b1, 2'b01, 8'h40, 16'($urandom), 1'b1, 8'h40);
    idle(3);
    for (int m = 0; m < 3; m++) check(m, "coll_cnt_sat", coll_cnt[m], 16'hFFFF);
`endif

    idle(3);
    for (int m = 0; m < 3; m++) check(m, "scoreboard_drained", sb[m].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
